// File: rtl/mmio_timer_intc.sv
// Memory-mapped bank of prescaled down-counters that feeds the MIPS interrupt vector.
// Bit 0 of intr carries the CP0 timer interrupt straight through.
module mmio_timer_intc #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PRE_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        sel,
  input  logic        intimer,
  output logic [5:0]  intr
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [PRE_WIDTH-1:0]  prescaleQ, preCntQ;
  logic [NUM_TIMERS-1:0] maskQ, enQ, autoQ, irqEnQ, pendQ, intrQ;
  logic [NUM_TIMERS-1:0] enD, autoD, irqEnD, pendD;
  logic [CNT_WIDTH-1:0]  loadQ  [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  countQ [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  loadD  [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  countD [NUM_TIMERS];

  logic       wrEn, tick, unusedBits;
  logic [3:0] chIdx;
  logic [1:0] regIdx;
  logic [4:0] intrHi;

  // Window is 512-byte aligned, so the upper address bits alone decide membership.
  assign sel        = ce && (addr[31:9] == BASE_ADDR[31:9]);
  assign wrEn       = ce && we && sel;
  assign chIdx      = addr[7:4];
  assign regIdx     = addr[3:2];
  assign tick       = (preCntQ == prescaleQ);
  assign unusedBits = ^{addr[1:0], wtData};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaleQ <= '0;
      preCntQ   <= '0;
      maskQ     <= '0;
    end else begin
      if (wrEn && (addr[8:2] == 7'd0)) begin
        prescaleQ <= wtData[PRE_WIDTH-1:0];
        preCntQ   <= '0;
      end else if (tick) begin
        preCntQ <= '0;
      end else begin
        preCntQ <= preCntQ + 1'b1;
      end
      if (wrEn && (addr[8:2] == 7'd1)) begin
        maskQ <= wtData[NUM_TIMERS-1:0];
      end
    end
  end

  always_comb begin
    enD    = enQ;
    autoD  = autoQ;
    irqEnD = irqEnQ;
    pendD  = pendQ;
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      loadD[i]  = loadQ[i];
      countD[i] = countQ[i];
      // W1C first so a same-cycle expiry below re-sets the flag.
      if (wrEn && addr[8] && (chIdx == 4'(i)) && (regIdx == 2'd3) && wtData[0]) begin
        pendD[i] = 1'b0;
      end
      if (tick && enQ[i] && (countQ[i] != '0)) begin
        if (countQ[i] == CntOne) begin
          pendD[i] = 1'b1;
          if (autoQ[i]) begin
            countD[i] = loadQ[i];
          end else begin
            countD[i] = '0;
            enD[i]    = 1'b0;
          end
        end else begin
          countD[i] = countQ[i] - CntOne;
        end
      end
      // Software writes override any same-cycle decrement or reload.
      if (wrEn && addr[8] && (chIdx == 4'(i))) begin
        case (regIdx)
          2'd0: begin
            enD[i]    = wtData[0];
            autoD[i]  = wtData[1];
            irqEnD[i] = wtData[2];
          end
          2'd1: begin
            loadD[i]  = wtData[CNT_WIDTH-1:0];
            countD[i] = wtData[CNT_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enQ    <= '0;
      autoQ  <= '0;
      irqEnQ <= '0;
      pendQ  <= '0;
      intrQ  <= '0;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        loadQ[i]  <= '0;
        countQ[i] <= '0;
      end
    end else begin
      enQ    <= enD;
      autoQ  <= autoD;
      irqEnQ <= irqEnD;
      pendQ  <= pendD;
      intrQ  <= pendQ & irqEnQ & maskQ;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        loadQ[i]  <= loadD[i];
        countQ[i] <= countD[i];
      end
    end
  end

  always_comb begin
    intrHi                 = '0;
    intrHi[NUM_TIMERS-1:0] = intrQ;
  end

  assign intr = {intrHi, intimer};

  always_comb begin
    rdData = '0;
    if (ce && !we && sel) begin
      if (!addr[8]) begin
        case (addr[7:2])
          6'd0:    rdData = 32'(prescaleQ);
          6'd1:    rdData = 32'(maskQ);
          6'd2:    rdData = 32'(pendQ & irqEnQ);
          default: rdData = '0;
        endcase
      end else begin
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
          if (chIdx == 4'(i)) begin
            case (regIdx)
              2'd0:    rdData = {29'd0, irqEnQ[i], autoQ[i], enQ[i]};
              2'd1:    rdData = 32'(loadQ[i]);
              2'd2:    rdData = 32'(countQ[i]);
              default: rdData = {31'd0, pendQ[i]};
            endcase
          end
        end
      end
    end
  end

endmodule
